// File: rtl/uart_debug_pkg.sv
// Shared types and constants for the uart_debug_mem debug target.
package uart_debug_pkg;

  typedef enum logic [1:0] {
    DISP_LAST_WR  = 2'd0,
    DISP_LAST_RD  = 2'd1,
    DISP_MEM_PAGE = 2'd2,
    DISP_PERF     = 2'd3
  } disp_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rd_state_e;

  localparam logic [31:0] DEFAULT_RDATA_C  = 32'hFCD09A23;
  localparam int unsigned MAX_READ_LATENCY = 4;

endpackage

// File: rtl/uart_debug_mem_if.sv
// Memory-side bus between uart_ip_memory_mapped (master) and uart_debug_mem (slave).
interface uart_debug_mem_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
);
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_waddr;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;

  modport master (
    output mem_we, mem_wdata, mem_waddr, mem_re, mem_raddr,
    input  mem_rdata, mem_rdy
  );

  modport slave (
    input  mem_we, mem_wdata, mem_waddr, mem_re, mem_raddr,
    output mem_rdata, mem_rdy
  );
endinterface

// File: rtl/uart_debug_btn_step.sv
// Pushbutton synchroniser with rising-edge detect; emits a one-cycle step pulse per press.
module uart_debug_btn_step (
  input  logic clk,
  input  logic arst,
  input  logic btn_i,
  output logic step_o
);
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign step_o = sync2_q & ~prev_q;
endmodule

// File: rtl/uart_debug_mem.sv
// DEPTH-word debug register file with fixed-latency read handshake and 7-segment word select.
// Optional perf counters: define UART_DEBUG_MEM_PERF_CNT_EN.
module uart_debug_mem
  import uart_debug_pkg::*;
#(
  parameter int unsigned NUM_BYTES_DATA    = 4,
  parameter int unsigned NUM_BYTES_ADDRESS = 1,
  parameter int unsigned DEPTH             = 16,
  parameter int unsigned READ_LATENCY      = 1,
  parameter logic [31:0] DEFAULT_RDATA     = DEFAULT_RDATA_C
) (
  input  logic                 clk,
  input  logic                 arst,
  uart_debug_mem_if.slave      bus,
  input  logic [1:0]           disp_mode,
  input  logic                 page_btn,
  output logic [31:0]          seg_data
);
  localparam int unsigned DW   = 8 * NUM_BYTES_DATA;
  localparam int unsigned AW   = 8 * NUM_BYTES_ADDRESS;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(MAX_READ_LATENCY);
  localparam logic [DW-1:0] DefRdata = DW'(DEFAULT_RDATA);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   mem_d [DEPTH];
  rd_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  // rdata_q doubles as last_rd: both load the same value on every completed read.
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [31:0]     last_wr_q, last_wr_d;
  logic [IdxW-1:0] disp_idx_q, disp_idx_d;
  logic [31:0]     seg_q, seg_d;
  logic            wr_ok, rd_ok, rd_done, step;
  logic [31:0]     perf_word;

  assign wr_ok = bus.mem_we && (32'(bus.mem_waddr) < DEPTH);
  assign rd_ok = 32'(raddr_q) < DEPTH;

  uart_debug_btn_step u_btn_step (
    .clk    (clk),
    .arst   (arst),
    .btn_i  (page_btn),
    .step_o (step)
  );

  always_comb begin
    mem_d     = mem_q;
    last_wr_d = last_wr_q;
    if (wr_ok) mem_d[bus.mem_waddr[IdxW-1:0]] = bus.mem_wdata;
    if (bus.mem_we) last_wr_d = 32'({bus.mem_wdata, bus.mem_waddr});
  end

  // Array is sampled at the completion edge, so writes up to the edge before it are visible.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    rd_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_re) begin
          raddr_d = bus.mem_raddr;
          cnt_d   = CntW'(READ_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = rd_ok ? mem_q[raddr_q[IdxW-1:0]] : DefRdata;
          rd_done = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    disp_idx_d = disp_idx_q;
    if (step) disp_idx_d = (disp_idx_q == IdxW'(DEPTH - 1)) ? '0 : disp_idx_q + IdxW'(1);
  end

  always_comb begin
    seg_d = '0;
    unique case (disp_mode_e'(disp_mode))
      DISP_LAST_WR:  seg_d = last_wr_q;
      DISP_LAST_RD:  seg_d = 32'(rdata_q);
      DISP_MEM_PAGE: seg_d = 32'(mem_q[disp_idx_q]);
      DISP_PERF:     seg_d = perf_word;
      default:       seg_d = '0;
    endcase
  end

`ifdef UART_DEBUG_MEM_PERF_CNT_EN
  logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_ok && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
    if (rd_done && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign perf_word = {wr_cnt_q, rd_cnt_q};
`else
  assign perf_word = '0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      raddr_q    <= '0;
      rdata_q    <= '0;
      last_wr_q  <= '0;
      disp_idx_q <= '0;
      seg_q      <= '0;
    end else begin
      mem_q      <= mem_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      raddr_q    <= raddr_d;
      rdata_q    <= rdata_d;
      last_wr_q  <= last_wr_d;
      disp_idx_q <= disp_idx_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_rdy   = (state_q == IDLE);
  assign seg_data      = seg_q;
endmodule

// File: tb/tb_uart_debug_mem.sv
// Randomised self-checking bench for uart_debug_mem against a behavioural array model.
module tb_uart_debug_mem;
  localparam int unsigned Lat  = 3;
  localparam int unsigned Dep  = 16;
  localparam logic [31:0] DefV = 32'hFCD09A23;

  logic        clk = 1'b0;
  logic        arst;
  logic [1:0]  disp_mode;
  logic        page_btn;
  logic [31:0] seg_data, seg_data1;

  uart_debug_mem_if #(.DW(32), .AW(8)) bus ();
  uart_debug_mem_if #(.DW(32), .AW(8)) bus1 ();

  uart_debug_mem #(.DEPTH(Dep), .READ_LATENCY(Lat)) u_dut (
    .clk       (clk),
    .arst      (arst),
    .bus       (bus.slave),
    .disp_mode (disp_mode),
    .page_btn  (page_btn),
    .seg_data  (seg_data)
  );

  uart_debug_mem #(.DEPTH(Dep), .READ_LATENCY(1)) u_dut1 (
    .clk       (clk),
    .arst      (arst),
    .bus       (bus1.slave),
    .disp_mode (disp_mode),
    .page_btn  (page_btn),
    .seg_data  (seg_data1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_mem [Dep];
  logic [31:0] m_last_wr;
  int          m_disp_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] exp_rd(input int a);
    return (a < Dep) ? m_mem[a] : DefV;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < Dep; i++) m_mem[i] = '0;
    m_last_wr  = '0;
    m_disp_idx = 0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    bus.mem_we    = 1'b1;
    bus.mem_waddr = 8'(a);
    bus.mem_wdata = d;
    tick();
    bus.mem_we = 1'b0;
    if (a < Dep) m_mem[a] = d;
    m_last_wr = 32'((64'(d) << 8) | 64'(a));
  endtask

  task automatic do_read(input int a, output logic [31:0] data, output int lat,
                         output logic rdy_at_req);
    bus.mem_re    = 1'b1;
    bus.mem_raddr = 8'(a);
    tick();
    bus.mem_re = 1'b0;
    rdy_at_req = bus.mem_rdy;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.mem_rdy !== 1'b1 && lat < 20);
    data = bus.mem_rdata;
  endtask

  task automatic test_reset();
    chk("reset_rdy", 32'(bus.mem_rdy), 32'd1);
    chk("reset_rdata", bus.mem_rdata, 32'd0);
    chk("reset_seg", seg_data, 32'd0);
  endtask

  task automatic test_write_disp();
    disp_mode = 2'd0;
    do_write(3, 32'hDEADBEEF);
    tick();
    chk("wr_seg_last_wr", seg_data, 32'hADBEEF03);
  endtask

  task automatic test_read_latency();
    bus.mem_re    = 1'b1;
    bus.mem_raddr = 8'd3;
    tick();
    chk("lat_rdy_e0", 32'(bus.mem_rdy), 32'd0);
    bus.mem_raddr = 8'd4;  // ignored: issued while busy
    tick();
    bus.mem_re = 1'b0;
    chk("lat_rdy_e1", 32'(bus.mem_rdy), 32'd0);
    tick();
    chk("lat_rdy_e2", 32'(bus.mem_rdy), 32'd0);
    tick();
    chk("lat_rdy_e3", 32'(bus.mem_rdy), 32'd1);
    chk("lat_data_e3", bus.mem_rdata, 32'hDEADBEEF);
    tick();
    chk("lat_ignored_rdy", 32'(bus.mem_rdy), 32'd1);
    chk("lat_ignored_data", bus.mem_rdata, 32'hDEADBEEF);
    disp_mode = 2'd1;
    tick();
    tick();
    chk("seg_last_rd", seg_data, 32'hDEADBEEF);
    disp_mode = 2'd0;
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    int          lat;
    logic        r0;
    do_read(200, d, lat, r0);
    chk("oor_read", d, DefV);
    chk("oor_lat", 32'(lat), 32'(Lat));
    do_write(20, 32'hA5A50001);
    tick();
    chk("oor_wr_last_wr", seg_data, m_last_wr);
    do_read(4, d, lat, r0);
    chk("oor_no_alias", d, exp_rd(4));
  endtask

  task automatic test_raw();
    logic [31:0] d;
    int          lat;
    logic        r0;
    bus1.mem_we    = 1'b1;
    bus1.mem_waddr = 8'd5;
    bus1.mem_wdata = 32'h12345678;
    bus1.mem_re    = 1'b1;
    bus1.mem_raddr = 8'd5;
    tick();
    bus1.mem_we = 1'b0;
    bus1.mem_re = 1'b0;
    chk("raw1_busy", 32'(bus1.mem_rdy), 32'd0);
    tick();
    chk("raw1_rdy", 32'(bus1.mem_rdy), 32'd1);
    chk("raw1_data", bus1.mem_rdata, 32'h12345678);
    // Write during WAIT is visible.
    bus.mem_re    = 1'b1;
    bus.mem_raddr = 8'd6;
    tick();
    bus.mem_re = 1'b0;
    do_write(6, 32'hCAFE0006);
    tick();
    tick();
    chk("raw_wait_data", bus.mem_rdata, 32'hCAFE0006);
    // Write on the completion edge is not visible.
    bus.mem_re    = 1'b1;
    bus.mem_raddr = 8'd7;
    tick();
    bus.mem_re = 1'b0;
    tick();
    tick();
    d = m_mem[7];
    do_write(7, 32'hBEEF0007);
    chk("raw_done_edge_old", bus.mem_rdata, d);
    do_read(7, d, lat, r0);
    chk("raw_done_edge_new", d, 32'hBEEF0007);
  endtask

  task automatic test_random();
    logic [31:0] d, wd;
    int          a, lat;
    logic        r0;
    disp_mode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      a  = int'($urandom_range(0, 31));
      wd = $urandom;
      do_write(a, wd);
      tick();
      chk("rnd_last_wr", seg_data, m_last_wr);
      a = int'($urandom_range(0, 31));
      do_read(a, d, lat, r0);
      chk("rnd_data", d, exp_rd(a));
      chk("rnd_lat", 32'(lat), 32'(Lat));
    end
  endtask

  task automatic test_page();
    for (int i = 0; i < Dep; i++) do_write(i, 32'(i));
    disp_mode = 2'd2;
    tick();
    tick();
    chk("page_start", seg_data, m_mem[m_disp_idx]);
    for (int p = 0; p < 17; p++) begin
      page_btn = 1'b1;
      repeat (3) tick();
      page_btn = 1'b0;
      repeat (5) tick();
      m_disp_idx = (m_disp_idx + 1) % Dep;
      chk("page_step", seg_data, m_mem[m_disp_idx]);
    end
    disp_mode = 2'd0;
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    int          lat;
    logic        r0;
    bus.mem_re    = 1'b1;
    bus.mem_raddr = 8'd3;
    tick();
    bus.mem_re = 1'b0;
    tick();
    #2 arst = 1'b1;
    #1;
    chk("arst_rdy", 32'(bus.mem_rdy), 32'd1);
    chk("arst_rdata", bus.mem_rdata, 32'd0);
    chk("arst_seg", seg_data, 32'd0);
    model_reset();
    @(negedge clk);
    arst = 1'b0;
    repeat (4) tick();
    chk("arst_no_data", bus.mem_rdata, 32'd0);
    chk("arst_idle", 32'(bus.mem_rdy), 32'd1);
    do_read(15, d, lat, r0);
    chk("arst_mem_clear", d, 32'd0);
  endtask

  task automatic test_perf();
    logic [31:0] d;
    int          lat;
    logic        r0;
    int          n_wr;
    int          n_rd;
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    tick();
    model_reset();
    disp_mode = 2'd3;
    n_wr = 0;
    n_rd = 0;
    for (int i = 0; i < 8; i++) begin
      int a;
      a = int'($urandom_range(0, 31));
      do_write(a, $urandom);
      if (a < Dep) n_wr++;
      if (i % 3 == 0) begin
        do_read(int'($urandom_range(0, 31)), d, lat, r0);
        n_rd++;
      end
    end
    tick();
`ifdef UART_DEBUG_MEM_PERF_CNT_EN
    chk("perf_counts", seg_data, {16'(n_wr), 16'(n_rd)});
    bus.mem_we    = 1'b1;
    bus.mem_waddr = 8'd1;
    bus.mem_wdata = 32'h1;
    repeat (70000) tick();
    bus.mem_we = 1'b0;
    tick();
    chk("perf_wr_sat", seg_data, {16'hFFFF, 16'(n_rd)});
`else
    chk("perf_disabled", seg_data, 32'd0);
`endif
    disp_mode = 2'd0;
  endtask

  initial begin
    arst           = 1'b1;
    disp_mode      = 2'd0;
    page_btn       = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = '0;
    bus.mem_waddr  = '0;
    bus.mem_re     = 1'b0;
    bus.mem_raddr  = '0;
    bus1.mem_we    = 1'b0;
    bus1.mem_wdata = '0;
    bus1.mem_waddr = '0;
    bus1.mem_re    = 1'b0;
    bus1.mem_raddr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    arst = 1'b0;
    tick();
    test_write_disp();
    test_read_latency();
    test_out_of_range();
    test_raw();
    test_random();
    test_page();
    test_reset_mid_read();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
